vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Generates 640x480@60 VGA raster timing from the 100 MHz system clock: pixel-rate tick,
//  h/v position counters, active-video flag and hsync/vsync. Sits directly upstream of
//  pixel_gen, driving its h_cnt and valid inputs (v_cnt and the tick feed mouse/overlay
//  logic). Syncs go to the VGA pins.
// PARAMETERS
//  CLK_DIV    4    system clocks per pixel (>=1); 100 MHz / 4 = 25 MHz pixel rate
//  H_VISIBLE  640  active pixels per line
//  H_FP       16   h front porch, pixels
//  H_SYNC     96   h sync width, pixels
//  H_BP       48   h back porch, pixels (H_TOTAL = 800)
//  V_VISIBLE  480  active lines per frame
//  V_FP       10   v front porch, lines
//  V_SYNC     2    v sync width, lines
//  V_BP       33   v back porch, lines (V_TOTAL = 525)
//  SYNC_POL   0    asserted sync level (0 = active-low)
// PORTS
//  clk          in   1   system clock, 100 MHz
//  rst          in   1   synchronous reset, active-high
//  pix_tick     out  1   1-clk pulse: h_cnt/v_cnt/valid/syncs just took a new value
//  h_cnt        out  10  horizontal position, 0..H_TOTAL-1
//  v_cnt        out  10  vertical position, 0..V_TOTAL-1
//  valid        out  1   1 when h_cnt<H_VISIBLE and v_cnt<V_VISIBLE
//  hsync        out  1   horizontal sync, SYNC_POL when asserted
//  vsync        out  1   vertical sync, SYNC_POL when asserted
//  line_start   out  1   1-clk pulse with pix_tick when h_cnt becomes 0
//  frame_start  out  1   1-clk pulse with pix_tick when (h_cnt,v_cnt) becomes (0,0)
// BEHAVIOUR
//  - Clock domain: single clock clk; reset is synchronous and active-high (rst).
//  - Divider: div counts 0..CLK_DIV-1, wraps; advance event when div==CLK_DIV-1.
//    CLK_DIV=1: advance every clk.
//  - On advance: h_cnt==H_TOTAL-1 -> h_cnt=0 and v advances, else h_cnt+1.
//    v_cnt==V_TOTAL-1 -> 0 on v advance, else v_cnt+1.
//  - All outputs registered; decoded from next counter values, so every output updates on
//    the same clk edge as h_cnt/v_cnt. Zero skew between position and valid/syncs.
//  - hsync asserted iff H_VISIBLE+H_FP <= h_cnt < H_VISIBLE+H_FP+H_SYNC (656..751).
//  - vsync asserted iff V_VISIBLE+V_FP <= v_cnt < V_VISIBLE+V_FP+V_SYNC (490..491).
//  - pix_tick/line_start/frame_start high for exactly one clk per event; low otherwise.
//  - Reset values: div=0, h_cnt=H_TOTAL-1 (799), v_cnt=V_TOTAL-1 (524), valid=0,
//    hsync=vsync=~SYNC_POL, pix_tick=line_start=frame_start=0.
//    Thus the first advance after reset lands on (0,0) with frame_start=1.
//  - Reset mid-frame: state returns to reset values on the next clk edge; no partial line
//    or stale sync pulse survives.
//  - Counters never exceed H_TOTAL-1 / V_TOTAL-1; widths fixed at 10 bits
//    (H_TOTAL, V_TOTAL <= 1024).
// CONFIGURATION
//  VGA_FRAME_CNT_EN defined: adds output frame_cnt [15:0]. Resets to 0, +1 on each
//  frame_start (same edge), wraps 16'hFFFF->0.
//  Undefined: port and counter absent; all other behaviour identical.
// TESTING
//  1. rst high 3 clks, release -> h=799,v=524,valid=0,syncs high; 4th clk after release:
//     h=0,v=0,valid=1,pix_tick=line_start=frame_start=1.
//  2. One line -> pix_tick every 4 clks; valid high h=0..639; hsync low h=656..751
//     (384 clks); line_start period 3200 clks.
//  3. Wrap -> h 799->0 same edge v+1; v 524->0 with frame_start=1;
//     frame_start period 1,680,000 clks.
//  4. Vertical -> vsync low only v=490..491 (6400 clks); valid=0 for all h when v>=480.
//  5. rst pulsed 1 clk at (h=300,v=200) -> next edge h=799,v=524,valid=0,syncs inactive;
//     then resumes at (0,0).
//  6. VGA_FRAME_CNT_EN: frame_cnt 0 -> 3 after 3 frame_start pulses; forced 16'hFFFF +
//     frame_start -> 0.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing (pixel tick, h/v counters, valid, syncs); define VGA_FRAME_CNT_EN to add a 16-bit frame_cnt output
module vga_timing_gen #(
   parameter int CLK_DIV   = 4,
   parameter int H_VISIBLE = 640,
   parameter int H_FP      = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BP      = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FP      = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BP      = 33,
   parameter bit SYNC_POL  = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   output logic        pix_tick,
   output logic [9:0]  h_cnt,
   output logic [9:0]  v_cnt,
   output logic        valid,
   output logic        hsync,
   output logic        vsync,
   output logic        line_start,
   output logic        frame_start
`ifdef VGA_FRAME_CNT_EN
   ,
   output logic [15:0] frame_cnt
`endif
);
   localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
   localparam int HS_BEG = H_VISIBLE + H_FP;
   localparam int HS_END = HS_BEG + H_SYNC;
   localparam int VS_BEG = V_VISIBLE + V_FP;
   localparam int VS_END = VS_BEG + V_SYNC;
   localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
   logic [DW-1:0] div;
   logic          adv;
   logic [9:0]    h_nxt;
   logic [9:0]    v_nxt;
   // Advance decode and next raster position; outputs are decoded from these so they land with the counters
   always_comb begin
      adv   = div == DIV_LAST;
      h_nxt = h_cnt == H_LAST ? 10'd0 : h_cnt + 10'd1;
      v_nxt = h_cnt != H_LAST ? v_cnt : v_cnt == V_LAST ? 10'd0 : v_cnt + 10'd1;
   end
   // Pixel divider, position counters and registered decodes; state only moves on an advance
   always_ff @(posedge clk) begin
      if (rst) begin
         div         <= '0;
         h_cnt       <= H_LAST;
         v_cnt       <= V_LAST;
         valid       <= 1'b0;
         hsync       <= ~SYNC_POL;
         vsync       <= ~SYNC_POL;
         pix_tick    <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         div         <= adv ? '0 : div + DW'(1);
         pix_tick    <= adv;
         line_start  <= adv && h_nxt == 10'd0;
         frame_start <= adv && h_nxt == 10'd0 && v_nxt == 10'd0;
         if (adv) begin
            h_cnt <= h_nxt;
            v_cnt <= v_nxt;
            valid <= int'(h_nxt) < H_VISIBLE && int'(v_nxt) < V_VISIBLE;
            hsync <= (int'(h_nxt) >= HS_BEG && int'(h_nxt) < HS_END) ? SYNC_POL : ~SYNC_POL;
            vsync <= (int'(v_nxt) >= VS_BEG && int'(v_nxt) < VS_END) ? SYNC_POL : ~SYNC_POL;
         end
      end
   end
`ifdef VGA_FRAME_CNT_EN
   // Frame counter steps on the same edge that raises frame_start and wraps naturally
   always_ff @(posedge clk) begin
      if (rst)
         frame_cnt <= '0;
      else if (adv && h_nxt == 10'd0 && v_nxt == 10'd0)
         frame_cnt <= frame_cnt + 16'd1;
   end
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench for vga_timing_gen on a small raster, plus default and CLK_DIV=1 instances
module tb_vga_timing_gen;
   typedef struct packed {
      logic [9:0] h;
      logic [9:0] v;
      logic va, hs, vs, ls, fs;
   } exp_t;
   // Small raster keeps full frames cheap: H_TOTAL=15, V_TOTAL=9, hsync h=10..12, vsync v=6..7
   localparam int DIV = 2, HV = 8, HF = 2, HS = 3, HB = 2, VV = 5, VF = 1, VS = 2, VB = 1;
   localparam int HT = 15, VT = 9;
   logic clk = 1'b0, rst = 1'b1;
   logic s_tick, s_va, s_hs, s_vs, s_ls, s_fs;
   logic [9:0] s_h, s_v;
   logic d_tick, d_va, d_hs, d_vs, d_ls, d_fs;
   logic [9:0] d_h, d_v;
   logic o_tick, o_va, o_hs, o_vs, o_ls, o_fs;
   logic [9:0] o_h, o_v;
`ifdef VGA_FRAME_CNT_EN
   logic [15:0] s_fc, d_fc, o_fc;
`endif
   int n_cmp = 0, n_err = 0;
   exp_t q[$];
   logic mon_en = 1'b0, go = 1'b0, def_done = 1'b0;
   int gap = 0, tix = 0, fs2 = 0, n_va = 0, n_hs = 0, n_vs = 0;

   always #5 clk = ~clk;

   vga_timing_gen #(.CLK_DIV(DIV), .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                    .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b0)) u_small (
      .clk(clk), .rst(rst), .pix_tick(s_tick), .h_cnt(s_h), .v_cnt(s_v), .valid(s_va),
      .hsync(s_hs), .vsync(s_vs), .line_start(s_ls), .frame_start(s_fs)
`ifdef VGA_FRAME_CNT_EN
      , .frame_cnt(s_fc)
`endif
   );

   vga_timing_gen u_def (
      .clk(clk), .rst(rst), .pix_tick(d_tick), .h_cnt(d_h), .v_cnt(d_v), .valid(d_va),
      .hsync(d_hs), .vsync(d_vs), .line_start(d_ls), .frame_start(d_fs)
`ifdef VGA_FRAME_CNT_EN
      , .frame_cnt(d_fc)
`endif
   );

   vga_timing_gen #(.CLK_DIV(1), .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                    .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b0)) u_div1 (
      .clk(clk), .rst(rst), .pix_tick(o_tick), .h_cnt(o_h), .v_cnt(o_v), .valid(o_va),
      .hsync(o_hs), .vsync(o_vs), .line_start(o_ls), .frame_start(o_fs)
`ifdef VGA_FRAME_CNT_EN
      , .frame_cnt(o_fc)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic exp_t s_now();
      return exp_t'({s_h, s_v, s_va, s_hs, s_vs, s_ls, s_fs});
   endfunction

   // Expected raster walk from (0,0), one entry per pixel tick
   task automatic push_ticks(input int n);
      int h = 0, v = 0;
      for (int i = 0; i < n; i++) begin
         q.push_back('{h: 10'(h), v: 10'(v), va: (h < HV && v < VV),
                       hs: !(h >= 10 && h <= 12), vs: !(v >= 6 && v <= 7),
                       ls: (h == 0), fs: (h == 0 && v == 0)});
         h++;
         if (h == HT) begin
            h = 0;
            v = (v + 1) % VT;
         end
      end
   endtask

   // Monitor: pops one expectation per pix_tick, checks tick spacing and pulse exclusivity
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (!mon_en) gap = 0;
      else begin
         gap++;
         if (!s_tick) check("idle_pulses", {s_ls, s_fs}, 0);
         else begin
            check("tick_gap", gap, DIV);
            gap = 0;
            if (q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL underflow: tick at h=%0d v=%0d with no expectation", s_h, s_v);
            end else begin
               e = q.pop_front();
               check("tick_state", s_now(), e);
            end
            if (tix < HT * VT) begin
               n_va += int'(s_va);
               n_hs += int'(!s_hs);
               n_vs += int'(!s_vs);
            end
            if (s_fs && tix > 0 && fs2 == 0) fs2 = tix;
            tix++;
         end
      end
   end

   // Default-parameter and CLK_DIV=1 instances after the first reset release
   initial begin
      int c, lo;
      wait (go);
      @(posedge clk); #1;
      check("div1_first", {o_tick, o_h, o_v, o_fs}, {1'b1, 10'd0, 10'd0, 1'b1});
      @(posedge clk); #1;
      check("div1_second", {o_tick, o_h, o_ls, o_fs}, {1'b1, 10'd1, 1'b0, 1'b0});
      @(posedge clk); #1;
      check("def_no_tick_yet", {d_tick, d_h}, {1'b0, 10'd799});
      @(posedge clk); #1;
      check("def_first", {d_tick, d_h, d_v, d_va, d_hs, d_vs, d_ls, d_fs},
            {1'b1, 20'd0, 5'b11111});
      c = 0;
      lo = 0;
      do begin
         @(posedge clk); #1;
         c++;
         if (!d_hs) lo++;
      end while (!d_ls && c < 4000);
      check("def_line_period", c, 3200);
      check("def_hsync_clks", lo, 384);
      def_done = 1'b1;
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("rst_small", s_now(), exp_t'({10'd14, 10'd8, 5'b01100}));
      check("rst_small_tick", s_tick, 0);
      check("rst_def", {d_tick, d_h, d_v, d_va, d_hs, d_vs, d_ls, d_fs},
            {1'b0, 10'd799, 10'd524, 5'b01100});
      check("rst_div1", {o_tick, o_h, o_v}, {1'b0, 10'd14, 10'd8});
`ifdef VGA_FRAME_CNT_EN
      check("rst_frame_cnt", s_fc, 0);
`endif
      push_ticks(2 * HT * VT + 5);
      @(negedge clk);
      rst = 1'b0;
      mon_en = 1'b1;
      go = 1'b1;
      for (int i = 0; i < 4000 && q.size() > 0; i++) @(posedge clk);
      mon_en = 1'b0;
      #2;
      check("drain1", q.size(), 0);
      check("valid_ticks_frame", n_va, 40);
      check("hsync_ticks_frame", n_hs, 27);
      check("vsync_ticks_frame", n_vs, 30);
      check("frame_period_ticks", fs2, 135);
`ifdef VGA_FRAME_CNT_EN
      check("frame_cnt_3", s_fc, 3);
`endif
      for (int i = 0; i < 5000 && !def_done; i++) @(posedge clk);
      check("def_done", def_done, 1);
      for (int i = 0; i < 1000 && !(s_h == 10'd11 && s_v == 10'd6); i++) begin
         @(posedge clk); #1;
      end
      check("mid_syncs_low", {s_h, s_v, s_hs, s_vs}, {10'd11, 10'd6, 2'b00});
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      check("rst_mid", s_now(), exp_t'({10'd14, 10'd8, 5'b01100}));
      check("rst_mid_tick", s_tick, 0);
      push_ticks(20);
      @(negedge clk);
      rst = 1'b0;
      mon_en = 1'b1;
      for (int i = 0; i < 200 && q.size() > 0; i++) @(posedge clk);
      mon_en = 1'b0;
      #2;
      check("drain2", q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
